// File: rtl/arty_reset_ctrl.sv
// -----------------------------------------------------------------------------
// arty_reset_ctrl
//
// Purpose:
//   Board-level reset sequencer for an Arty-style SoC. It brings the three
//   asynchronous board inputs into the clk domain, optionally debounces the
//   push-button and the slide switch, then walks a four-state bring-up FSM:
//
//     WAIT_LOCK (00) -> HOLD (01) -> RUN_DELAY (10) -> RUN (11)
//
//   The SoC reset is held low through WAIT_LOCK and HOLD. It is released on
//   entry to RUN_DELAY. Fetch enable may only rise in RUN, and only while the
//   accepted switch level is high. Losing lock or pressing the button in any
//   active state drops straight back to WAIT_LOCK.
//
// Configuration:
//   ARTY_RESET_CTRL_DEBOUNCE_EN
//     defined   : button and switch go through a per-input debounce counter.
//                 A new level is accepted after DEBOUNCE_CYCLES consecutive
//                 mismatching cycles.
//     undefined : the accepted levels are the synchronizer outputs. No
//                 debounce counters are built, and DEBOUNCE_CYCLES has no
//                 effect on the logic.
//
// Parameters:
//   DEBOUNCE_CYCLES    : consecutive mismatch cycles to accept a level (>= 2)
//   RESET_HOLD_CYCLES  : cycles in HOLD before SoC reset release      (>= 2)
//   FETCH_DELAY_CYCLES : cycles in RUN_DELAY before fetch may enable  (>= 2)
//
// Ports:
//   clk           in   system clock; the only clock domain
//   rst_n         in   synchronous active-low reset
//   btn_rst_i     in   raw reset button, active high, asynchronous
//   sw_fetch_i    in   raw fetch-enable switch, active high, asynchronous
//   pll_locked_i  in   MMCM lock, asynchronous
//   soc_rst_n_o   out  registered active-low SoC reset
//   fetch_en_o    out  registered core fetch enable
//   state_o       out  FSM state register (also used to drive LEDs)
// -----------------------------------------------------------------------------
module arty_reset_ctrl #(
  parameter int DEBOUNCE_CYCLES    = 500000,
  parameter int RESET_HOLD_CYCLES  = 1024,
  parameter int FETCH_DELAY_CYCLES = 256
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_rst_i,
  input  logic       sw_fetch_i,
  input  logic       pll_locked_i,
  output logic       soc_rst_n_o,
  output logic       fetch_en_o,
  output logic [1:0] state_o
);

  // ---------------------------------------------------------------------------
  // Elaboration-time parameter range checks.
  // ---------------------------------------------------------------------------
  if (DEBOUNCE_CYCLES < 2) begin : g_bad_debounce
    $error("arty_reset_ctrl: DEBOUNCE_CYCLES must be at least 2");
  end
  if (RESET_HOLD_CYCLES < 2) begin : g_bad_hold
    $error("arty_reset_ctrl: RESET_HOLD_CYCLES must be at least 2");
  end
  if (FETCH_DELAY_CYCLES < 2) begin : g_bad_fetch
    $error("arty_reset_ctrl: FETCH_DELAY_CYCLES must be at least 2");
  end

  // ---------------------------------------------------------------------------
  // State encoding. The encoding is visible on state_o.
  // ---------------------------------------------------------------------------
  typedef enum logic [1:0] {
    ST_WAIT_LOCK = 2'b00,
    ST_HOLD      = 2'b01,
    ST_RUN_DELAY = 2'b10,
    ST_RUN       = 2'b11
  } state_t;

  // HOLD and RUN_DELAY never overlap, so they share one counter. It is sized
  // for the larger of the two terminal values.
  localparam int FSM_MAX = (RESET_HOLD_CYCLES > FETCH_DELAY_CYCLES) ?
                           RESET_HOLD_CYCLES : FETCH_DELAY_CYCLES;
  localparam int FSM_CW  = $clog2(FSM_MAX);

  localparam logic [FSM_CW-1:0] HOLD_LAST  = FSM_CW'(RESET_HOLD_CYCLES - 1);
  localparam logic [FSM_CW-1:0] FETCH_LAST = FSM_CW'(FETCH_DELAY_CYCLES - 1);

  // ---------------------------------------------------------------------------
  // Two-flop synchronizers.
  // Bit 0 = button, bit 1 = switch, bit 2 = PLL lock.
  // ---------------------------------------------------------------------------
  logic [2:0] r_sync_meta;
  logic [2:0] r_sync;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sync_meta <= '0;
      r_sync      <= '0;
    end else begin
      r_sync_meta <= {pll_locked_i, sw_fetch_i, btn_rst_i};
      r_sync      <= r_sync_meta;
    end
  end

  logic w_btn_sync;
  logic w_sw_sync;
  logic w_lock_sync;

  assign w_btn_sync  = r_sync[0];
  assign w_sw_sync   = r_sync[1];
  // Lock comes from the MMCM and is clean, so it is used without debouncing.
  assign w_lock_sync = r_sync[2];

  // ---------------------------------------------------------------------------
  // Accepted (debounced) button and switch levels.
  // ---------------------------------------------------------------------------
  logic w_btn_acc;
  logic w_sw_acc;

`ifdef ARTY_RESET_CTRL_DEBOUNCE_EN
  localparam int DB_CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [DB_CW-1:0] DB_LAST = DB_CW'(DEBOUNCE_CYCLES - 1);

  logic [DB_CW-1:0] r_btn_cnt;
  logic [DB_CW-1:0] r_sw_cnt;
  logic             r_btn_acc;
  logic             r_sw_acc;

  // Each counter runs only while the synced level disagrees with the accepted
  // level. Any agreeing cycle restarts the count. The counter stops at
  // DB_LAST, where the new level is taken, so it can never wrap.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_btn_cnt <= '0;
      r_sw_cnt  <= '0;
      r_btn_acc <= 1'b0;
      r_sw_acc  <= 1'b0;
    end else begin
      if (w_btn_sync != r_btn_acc) begin
        if (r_btn_cnt == DB_LAST) begin
          r_btn_acc <= w_btn_sync;
          r_btn_cnt <= '0;
        end else begin
          r_btn_cnt <= r_btn_cnt + 1'b1;
        end
      end else begin
        r_btn_cnt <= '0;
      end

      if (w_sw_sync != r_sw_acc) begin
        if (r_sw_cnt == DB_LAST) begin
          r_sw_acc <= w_sw_sync;
          r_sw_cnt <= '0;
        end else begin
          r_sw_cnt <= r_sw_cnt + 1'b1;
        end
      end else begin
        r_sw_cnt <= '0;
      end
    end
  end

  assign w_btn_acc = r_btn_acc;
  assign w_sw_acc  = r_sw_acc;
`else
  assign w_btn_acc = w_btn_sync;
  assign w_sw_acc  = w_sw_sync;
`endif

  // The SoC may run only while the clock is locked and the button is released.
  logic w_run_ok;
  assign w_run_ok = w_lock_sync & ~w_btn_acc;

  // ---------------------------------------------------------------------------
  // Bring-up FSM with registered outputs.
  // Outputs are written in the same branch that selects the next state, so
  // they always describe the state being entered on that edge.
  // ---------------------------------------------------------------------------
  state_t            r_state;
  logic [FSM_CW-1:0] r_cnt;
  logic              r_soc_rst_n;
  logic              r_fetch_en;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= ST_WAIT_LOCK;
      r_cnt       <= '0;
      r_soc_rst_n <= 1'b0;
      r_fetch_en  <= 1'b0;
    end else if ((r_state != ST_WAIT_LOCK) && !w_run_ok) begin
      // An abort wins over counter expiry on the same edge.
      r_state     <= ST_WAIT_LOCK;
      r_cnt       <= '0;
      r_soc_rst_n <= 1'b0;
      r_fetch_en  <= 1'b0;
    end else begin
      case (r_state)
        ST_WAIT_LOCK: begin
          r_soc_rst_n <= 1'b0;
          r_fetch_en  <= 1'b0;
          r_cnt       <= '0;
          if (w_run_ok) begin
            r_state <= ST_HOLD;
          end
        end

        ST_HOLD: begin
          r_fetch_en <= 1'b0;
          if (r_cnt == HOLD_LAST) begin
            r_state     <= ST_RUN_DELAY;
            r_cnt       <= '0;
            r_soc_rst_n <= 1'b1;
          end else begin
            r_cnt       <= r_cnt + 1'b1;
            r_soc_rst_n <= 1'b0;
          end
        end

        ST_RUN_DELAY: begin
          r_soc_rst_n <= 1'b1;
          if (r_cnt == FETCH_LAST) begin
            r_state    <= ST_RUN;
            r_cnt      <= '0;
            r_fetch_en <= w_sw_acc;
          end else begin
            r_cnt      <= r_cnt + 1'b1;
            r_fetch_en <= 1'b0;
          end
        end

        ST_RUN: begin
          // The switch gates fetch live in RUN without leaving the state.
          r_soc_rst_n <= 1'b1;
          r_fetch_en  <= w_sw_acc;
          r_cnt       <= '0;
        end

        default: begin
          r_state     <= ST_WAIT_LOCK;
          r_cnt       <= '0;
          r_soc_rst_n <= 1'b0;
          r_fetch_en  <= 1'b0;
        end
      endcase
    end
  end

  assign state_o     = r_state;
  assign soc_rst_n_o = r_soc_rst_n;
  assign fetch_en_o  = r_fetch_en;

endmodule

// File: tb/tb_arty_reset_ctrl.sv
// -----------------------------------------------------------------------------
// tb_arty_reset_ctrl
//
// Bench for arty_reset_ctrl with DEBOUNCE=4, HOLD=8 and FETCH_DELAY=4.
// Expectations follow ARTY_RESET_CTRL_DEBOUNCE_EN in the same way the DUT does.
//
// Each task queues the expected {state_o, soc_rst_n_o, fetch_en_o} value for
// every edge it is about to drive. It then pops one entry per edge and checks
// it 1 ns after the rising edge. Inputs change right after that sample, so the
// next rising edge is edge 1 for the new input value.
// -----------------------------------------------------------------------------
module tb_arty_reset_ctrl;

  localparam int DB   = 4;
  localparam int HOLD = 8;
  localparam int FD   = 4;

`ifdef ARTY_RESET_CTRL_DEBOUNCE_EN
  localparam int DB_LAT = DB;
`else
  localparam int DB_LAT = 0;
`endif

  // Observed tuple {state[1:0], soc_rst_n, fetch_en}
  localparam logic [3:0] O_WAIT    = 4'b0000;
  localparam logic [3:0] O_HOLD    = 4'b0100;
  localparam logic [3:0] O_DLY     = 4'b1010;
  localparam logic [3:0] O_RUN     = 4'b1111;
  localparam logic [3:0] O_RUN_NOF = 4'b1110;

  // Bring-up milestones counted from the first edge that samples lock high.
  // Lock becomes visible after edge 2, so HOLD is entered on edge 3.
  localparam int E_HOLD = 3;
  localparam int E_DLY  = E_HOLD + HOLD;  // 11
  localparam int E_RUN  = E_DLY + FD;     // 15
  localparam int N_BRINGUP = E_RUN + 2;   // 17

  // ---------------------------------------------------------------------------
  // Clock and reset
  // ---------------------------------------------------------------------------
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic btn   = 1'b0;
  logic sw    = 1'b0;
  logic lock  = 1'b0;

  logic       soc_rst_n;
  logic       fetch_en;
  logic [1:0] state;

  always #5 clk = ~clk;

  arty_reset_ctrl #(
    .DEBOUNCE_CYCLES   (DB),
    .RESET_HOLD_CYCLES (HOLD),
    .FETCH_DELAY_CYCLES(FD)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .btn_rst_i   (btn),
    .sw_fetch_i  (sw),
    .pll_locked_i(lock),
    .soc_rst_n_o (soc_rst_n),
    .fetch_en_o  (fetch_en),
    .state_o     (state)
  );

  logic [3:0] obs;
  assign obs = {state, soc_rst_n, fetch_en};

  // ---------------------------------------------------------------------------
  // Scoreboard state
  // ---------------------------------------------------------------------------
  logic [3:0] exp_q[$];
  logic [3:0] exp_v;
  int total = 0;
  int bad   = 0;

  // Expected tuple at edge e of a clean bring-up. Edges at or before 0 mean
  // the FSM is still waiting.
  function automatic logic [3:0] exp_bringup(input int e);
    if (e < E_HOLD)     return O_WAIT;
    else if (e < E_DLY) return O_HOLD;
    else if (e < E_RUN) return O_DLY;
    else                return O_RUN;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------------------------------------------------------------------
  // Driver / checker tasks
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    // Lock and switch are already high, so reset has to dominate them.
    rst_n = 1'b0; lock = 1'b1; sw = 1'b1; btn = 1'b0;
    for (int i = 1; i <= 4; i++) exp_q.push_back(O_WAIT);
    for (int i = 1; i <= 4; i++) begin
      tick();
      exp_v = exp_q.pop_front();
      total++;
      if (obs !== exp_v) begin
        bad++;
        $display("FAIL reset edge %0d: got %b want %b", i, obs, exp_v);
      end
    end
  endtask

  task automatic test_bringup();
    rst_n = 1'b1;
    for (int e = 1; e <= N_BRINGUP; e++) exp_q.push_back(exp_bringup(e));
    for (int i = 1; i <= N_BRINGUP; i++) begin
      tick();
      exp_v = exp_q.pop_front();
      total++;
      if (obs !== exp_v) begin
        bad++;
        $display("FAIL bringup edge %0d: got %b want %b", i, obs, exp_v);
      end
    end
  endtask

  task automatic test_lock_loss();
    lock = 1'b0;
    exp_q.push_back(O_RUN);
    exp_q.push_back(O_RUN);
    for (int i = 3; i <= 6; i++) exp_q.push_back(O_WAIT);
    for (int i = 1; i <= 6; i++) begin
      tick();
      exp_v = exp_q.pop_front();
      total++;
      if (obs !== exp_v) begin
        bad++;
        $display("FAIL lock_loss edge %0d: got %b want %b", i, obs, exp_v);
      end
    end
    lock = 1'b1;
    for (int e = 1; e <= N_BRINGUP; e++) exp_q.push_back(exp_bringup(e));
    for (int i = 1; i <= N_BRINGUP; i++) begin
      tick();
      exp_v = exp_q.pop_front();
      total++;
      if (obs !== exp_v) begin
        bad++;
        $display("FAIL lock_restore edge %0d: got %b want %b", i, obs, exp_v);
      end
    end
  endtask

  task automatic test_button();
`ifdef ARTY_RESET_CTRL_DEBOUNCE_EN
    // A 3-cycle glitch never reaches the debounce threshold.
    btn = 1'b1;
    for (int i = 1; i <= 10; i++) exp_q.push_back(O_RUN);
    for (int i = 1; i <= 10; i++) begin
      tick();
      if (i == 3) btn = 1'b0;
      exp_v = exp_q.pop_front();
      total++;
      if (obs !== exp_v) begin
        bad++;
        $display("FAIL btn_glitch edge %0d: got %b want %b", i, obs, exp_v);
      end
    end
    // A 4-cycle press is accepted at edge 6 and aborts at edge 7. The release
    // is accepted at edge 10, so HOLD restarts at edge 11 (bring-up shifted by 8).
    btn = 1'b1;
    for (int e = 1; e <= 6; e++) exp_q.push_back(O_RUN);
    for (int e = 7; e <= 8 + N_BRINGUP; e++) exp_q.push_back(exp_bringup(e - 8));
    for (int i = 1; i <= 8 + N_BRINGUP; i++) begin
      tick();
      if (i == 4) btn = 1'b0;
      exp_v = exp_q.pop_front();
      total++;
      if (obs !== exp_v) begin
        bad++;
        $display("FAIL btn_press edge %0d: got %b want %b", i, obs, exp_v);
      end
    end
`else
    // A 1-cycle pulse aborts at edge 3. HOLD restarts at edge 4.
    btn = 1'b1;
    exp_q.push_back(O_RUN);
    exp_q.push_back(O_RUN);
    for (int e = 3; e <= 1 + N_BRINGUP; e++) exp_q.push_back(exp_bringup(e - 1));
    for (int i = 1; i <= 1 + N_BRINGUP; i++) begin
      tick();
      if (i == 1) btn = 1'b0;
      exp_v = exp_q.pop_front();
      total++;
      if (obs !== exp_v) begin
        bad++;
        $display("FAIL btn_pulse edge %0d: got %b want %b", i, obs, exp_v);
      end
    end
`endif
  endtask

  task automatic test_switch();
    // Switch low: fetch drops at edge 3 + DB_LAT while the SoC stays out of reset.
    sw = 1'b0;
    for (int e = 1; e <= 10 + DB_LAT; e++)
      exp_q.push_back((e < 3 + DB_LAT) ? O_RUN : O_RUN_NOF);
    for (int i = 1; i <= 10 + DB_LAT; i++) begin
      tick();
      exp_v = exp_q.pop_front();
      total++;
      if (obs !== exp_v) begin
        bad++;
        $display("FAIL sw_off edge %0d: got %b want %b", i, obs, exp_v);
      end
    end
    // Switch high again: fetch returns with the same latency.
    sw = 1'b1;
    for (int e = 1; e <= 10 + DB_LAT; e++)
      exp_q.push_back((e < 3 + DB_LAT) ? O_RUN_NOF : O_RUN);
    for (int i = 1; i <= 10 + DB_LAT; i++) begin
      tick();
      exp_v = exp_q.pop_front();
      total++;
      if (obs !== exp_v) begin
        bad++;
        $display("FAIL sw_on edge %0d: got %b want %b", i, obs, exp_v);
      end
    end
  endtask

  task automatic test_collision();
    // Return to WAIT_LOCK first.
    lock = 1'b0;
    exp_q.push_back(O_RUN);
    exp_q.push_back(O_RUN);
    for (int i = 3; i <= 6; i++) exp_q.push_back(O_WAIT);
    for (int i = 1; i <= 6; i++) begin
      tick();
      exp_v = exp_q.pop_front();
      total++;
      if (obs !== exp_v) begin
        bad++;
        $display("FAIL collide_prep edge %0d: got %b want %b", i, obs, exp_v);
      end
    end
    // Lock is dropped after edge 8, so lock_sync reads 0 on edge 11. That is
    // the same edge on which HOLD would otherwise expire into RUN_DELAY.
    lock = 1'b1;
    for (int e = 1; e <= 10; e++) exp_q.push_back(exp_bringup(e));
    for (int e = 11; e <= 14; e++) exp_q.push_back(O_WAIT);
    for (int i = 1; i <= 14; i++) begin
      tick();
      if (i == 8) lock = 1'b0;
      exp_v = exp_q.pop_front();
      total++;
      if (obs !== exp_v) begin
        bad++;
        $display("FAIL collide edge %0d: got %b want %b", i, obs, exp_v);
      end
    end
    lock = 1'b1;
    for (int e = 1; e <= N_BRINGUP; e++) exp_q.push_back(exp_bringup(e));
    for (int i = 1; i <= N_BRINGUP; i++) begin
      tick();
      exp_v = exp_q.pop_front();
      total++;
      if (obs !== exp_v) begin
        bad++;
        $display("FAIL collide_recover edge %0d: got %b want %b", i, obs, exp_v);
      end
    end
  endtask

  task automatic test_reset_mid_run();
    // Reset while in RUN takes effect on the next edge.
    rst_n = 1'b0;
    for (int i = 1; i <= 3; i++) exp_q.push_back(O_WAIT);
    for (int i = 1; i <= 3; i++) begin
      tick();
      exp_v = exp_q.pop_front();
      total++;
      if (obs !== exp_v) begin
        bad++;
        $display("FAIL reset_run edge %0d: got %b want %b", i, obs, exp_v);
      end
    end
    // Release, let the FSM reach HOLD, then reset again from HOLD.
    rst_n = 1'b1;
    for (int e = 1; e <= 6; e++) exp_q.push_back(exp_bringup(e));
    for (int e = 7; e <= 8; e++) exp_q.push_back(O_WAIT);
    for (int i = 1; i <= 8; i++) begin
      tick();
      if (i == 6) rst_n = 1'b0;
      exp_v = exp_q.pop_front();
      total++;
      if (obs !== exp_v) begin
        bad++;
        $display("FAIL reset_hold edge %0d: got %b want %b", i, obs, exp_v);
      end
    end
    // Full bring-up again from a clean reset.
    rst_n = 1'b1;
    for (int e = 1; e <= N_BRINGUP; e++) exp_q.push_back(exp_bringup(e));
    for (int i = 1; i <= N_BRINGUP; i++) begin
      tick();
      exp_v = exp_q.pop_front();
      total++;
      if (obs !== exp_v) begin
        bad++;
        $display("FAIL reset_recover edge %0d: got %b want %b", i, obs, exp_v);
      end
    end
  endtask

  // ---------------------------------------------------------------------------
  // Sequence and final report
  // ---------------------------------------------------------------------------
  initial begin
    test_reset();
    test_bringup();
    test_lock_loss();
    test_button();
    test_switch();
    test_collision();
    test_reset_mid_run();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/arty_reset_ctrl.md
ARTY_RESET_CTRL -- requirements
Module: arty_reset_ctrl

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 500000, meaning the number of consecutive cycles a synchronized button/switch level must differ before it is accepted (minimum 2).
REQ-002 SHALL have parameter RESET_HOLD_CYCLES, default 1024, meaning the cycles SoC reset is held after lock and button release (minimum 2).
REQ-003 SHALL have parameter FETCH_DELAY_CYCLES, default 256, meaning the cycles between SoC reset release and the earliest fetch enable (minimum 2).
REQ-004 clk  input  1  system clock (50 MHz MMCM output); single clock domain for all state.
REQ-005 rst_n  input  1  synchronous active-low reset.
REQ-006 btn_rst_i  input  1  raw reset push-button, active high, asynchronous to clk.
REQ-007 sw_fetch_i  input  1  raw fetch-enable slide switch, active high, asynchronous to clk.
REQ-008 pll_locked_i  input  1  MMCM lock indicator, asynchronous to clk.
REQ-009 soc_rst_n_o  output  1  registered active-low reset to the SoC.
REQ-010 fetch_en_o  output  1  registered fetch enable to the SoC core.
REQ-011 state_o  output  2  current FSM state encoding, for LEDs.

Function
REQ-012 SHALL pass btn_rst_i, sw_fetch_i and pll_locked_i each through a two-flop synchronizer; synchronized level is visible after the 2nd rising edge.
REQ-013 SHALL debounce synchronized button and switch: per-input counter increments on each edge where synced level differs from the accepted level, and clears on any edge where they match.
REQ-014 SHALL update the accepted level on the edge where the mismatch persists and the counter equals DEBOUNCE_CYCLES-1, clearing the counter on that edge.
REQ-015 SHALL NOT debounce pll_locked; the synchronized value is used directly.
REQ-016 SHALL implement FSM states WAIT_LOCK=2'b00, HOLD=2'b01, RUN_DELAY=2'b10, RUN=2'b11, with state_o equal to the state register.
REQ-017 WAIT_LOCK: go to HOLD with hold counter cleared when lock_sync=1 and accepted button=0; otherwise stay.
REQ-018 HOLD: increment counter each edge; go to RUN_DELAY on the edge where counter equals RESET_HOLD_CYCLES-1, clearing the counter.
REQ-019 RUN_DELAY: increment counter each edge; go to RUN on the edge where counter equals FETCH_DELAY_CYCLES-1.
REQ-020 HOLD, RUN_DELAY, RUN: lock_sync=0 or accepted button=1 SHALL force WAIT_LOCK on the next edge, with priority over counter expiry when both occur on the same edge.
REQ-021 soc_rst_n_o SHALL be 1 exactly while state is RUN_DELAY or RUN, updated on the same edge as the state register.
REQ-022 fetch_en_o SHALL be 1 exactly while state is RUN and accepted switch=1, updated on the same edge as the state register; toggling the switch in RUN changes fetch_en_o without leaving RUN.
REQ-023 Counters SHALL be sized to hold the largest parameter value minus 1 and SHALL never wrap.

Reset
REQ-024 With rst_n=0 at an edge: state=WAIT_LOCK, soc_rst_n_o=0, fetch_en_o=0, all counters=0, synchronizer flops=0, accepted levels=0.
REQ-025 rst_n asserted mid-operation in any state SHALL take effect on that edge with the values of REQ-024.

Configuration
REQ-026 Macro ARTY_RESET_CTRL_DEBOUNCE_EN defined: button and switch are debounced per REQ-013/014.
REQ-027 Macro undefined: the accepted level equals the synchronized level directly, the debounce counters are not instantiated, and DEBOUNCE_CYCLES is ignored.

Verification (bench params: DEBOUNCE=4, HOLD=8, FETCH_DELAY=4; edges counted from the first edge sampling the new input value)
REQ-028 Bring-up: rst_n released, btn=0, sw=1, lock rises -> soc_rst_n_o=1 at edge 11; fetch_en_o=1 at edge 15; state_o sequence 00,01,10,11.
REQ-029 Lock loss: in RUN, drop lock -> edge 3: state=00, soc_rst_n_o=0, fetch_en_o=0; restore lock -> full REQ-028 timing again.
REQ-030 Debounce, macro defined: in RUN, btn high for 3 cycles then low -> no state change; btn high for 4 cycles -> accepted level updates at edge 6 and state=00 at edge 7.
REQ-031 Debounce, macro undefined: btn pulse of 1 cycle in RUN -> state=00 at edge 3.
REQ-032 Switch in RUN: sw 1->0 held -> fetch_en_o=0 at edge 7 (defined) or edge 3 (undefined) while soc_rst_n_o stays 1.
REQ-033 Collision and reset: lock drop synchronized on the HOLD expiry edge -> WAIT_LOCK, not RUN_DELAY; rst_n=0 in RUN -> next edge all outputs 0, state_o=00.
